// File: rtl/seg7_pkg.sv
// Shared definitions for the score seven-segment scanner.
//   - Glyph constants, active-low {g,f,e,d,c,b,a}
//   - Digit-select state enum (one state per displayed digit)
//   - Active-low anode patterns and small helpers for the scan sequence
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } dig_e;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    // Scan order wraps from the thousands digit back to the units digit.
    function automatic dig_e next_dig(input dig_e d);
        case (d)
            DIG0:    return DIG1;
            DIG1:    return DIG2;
            DIG2:    return DIG3;
            default: return DIG0;
        endcase
    endfunction

    function automatic logic [3:0] dig_anode(input dig_e d);
        case (d)
            DIG0:    return AN_DIG0;
            DIG1:    return AN_DIG1;
            DIG2:    return AN_DIG2;
            default: return AN_DIG3;
        endcase
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational BCD nibble to seven-segment glyph decoder.
// Ports:
//   nibble_i  in  4  BCD digit value; values above 9 render as a dash
//   blank_i   in  1  force an all-off glyph (used for leading-zero blanking)
//   seg_o     out 7  {g,f,e,d,c,b,a}, active-low
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (nibble_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/score_seg7_scan.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display
// showing a packed-BCD score. One digit is selected per dwell period; the
// first BLANK_CYCLES of each dwell keep all anodes off to suppress ghosting.
// The score is captured once per frame so a mid-frame update never tears.
// Ports:
//   CLK         in  1   system clock, rising edge
//   RST_N       in  1   synchronous active-low reset
//   bcdScore    in  16  packed BCD score, nibble k = digit k
//   seg         out 7   {g,f,e,d,c,b,a}, active-low
//   dp          out 1   decimal point, active-low, held off
//   an          out 4   digit anodes, active-low one-hot
//   frame_tick  out 1   pulses for one cycle when a new snapshot is taken
module score_seg7_scan
    import seg7_pkg::*;
#(
    parameter int DWELL        = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int LZ_BLANK     = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] bcdScore,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int            CW        = $clog2(DWELL);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    dig_e          state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [15:0]   snap_q,  snap_d;
    logic [6:0]    seg_q,   seg_d;
    logic [3:0]    an_q,    an_d;
    logic          tick_q,  tick_d;

    logic [3:0]    cur_nib;
    logic          cur_lz;
    logic [6:0]    cur_glyph;

    // Current digit and whether it is a leading zero: the digit and every
    // higher digit are zero. Digit 0 never counts, so a zero score shows "0".
    always_comb begin
        cur_nib = snap_q[3:0];
        cur_lz  = 1'b0;
        case (state_q)
            DIG1: begin
                cur_nib = snap_q[7:4];
                cur_lz  = (snap_q[15:4] == 12'h000);
            end
            DIG2: begin
                cur_nib = snap_q[11:8];
                cur_lz  = (snap_q[15:8] == 8'h00);
            end
            DIG3: begin
                cur_nib = snap_q[15:12];
                cur_lz  = (snap_q[15:12] == 4'h0);
            end
            default: begin
                cur_nib = snap_q[3:0];
                cur_lz  = 1'b0;
            end
        endcase
    end

    seg7_glyph u_glyph (
        .nibble_i (cur_nib),
        .blank_i  ((LZ_BLANK != 0) && cur_lz),
        .seg_o    (cur_glyph)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = next_dig(state_q);
        end

        // Frame start: capture the score. The output at this edge is in the
        // blank window, so the stale snapshot is never displayed.
        snap_d = snap_q;
        tick_d = 1'b0;
        if ((state_q == DIG0) && (cnt_q == '0)) begin
            snap_d = bcdScore;
            tick_d = 1'b1;
        end

        // A blanked leading zero still drives its anode so every digit gets
        // the same duty cycle.
        if (cnt_q < CNT_BLANK) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
        end else begin
            an_d  = dig_anode(state_q);
            seg_d = cur_glyph;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= DIG0;
            cnt_q   <= '0;
            snap_q  <= 16'h0000;
            seg_q   <= SEG_BLANK;
            an_q    <= AN_OFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;
    assign dp         = 1'b1;

endmodule

// File: tb/tb_score_seg7_scan.sv
// Bench for score_seg7_scan with a short dwell. Two instances share inputs:
// one with leading-zero blanking, one without.
module tb_score_seg7_scan;

    localparam int DWELL = 4;
    localparam int BLANK = 1;
    localparam int FRAME = 4 * DWELL;

    logic        CLK;
    logic        RST_N;
    logic [15:0] bcdScore;
    logic [6:0]  seg,  seg_nz;
    logic        dp,   dp_nz;
    logic [3:0]  an,   an_nz;
    logic        frame_tick, ft_nz;

    score_seg7_scan #(.DWELL(DWELL), .BLANK_CYCLES(BLANK), .LZ_BLANK(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .bcdScore(bcdScore),
        .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
    );

    score_seg7_scan #(.DWELL(DWELL), .BLANK_CYCLES(BLANK), .LZ_BLANK(0)) dut_nz (
        .CLK(CLK), .RST_N(RST_N), .bcdScore(bcdScore),
        .seg(seg_nz), .dp(dp_nz), .an(an_nz), .frame_tick(ft_nz)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: position within the frame counted in edges since
    // reset release; digit = position / DWELL, phase = position % DWELL.
    logic [6:0]  glyph_tbl [16];
    int          m_pos;
    logic [15:0] m_snap;
    logic [3:0]  m_an;
    logic [6:0]  m_seg, m_seg_nz;
    logic        m_ft;

    function automatic logic [6:0] ref_glyph(input logic [15:0] s, input int d, input bit lz);
        logic [15:0] hi;
        hi = s >> (4 * d);
        if (lz && d > 0 && hi == 16'h0) return 7'h7F;
        return glyph_tbl[hi[3:0]];
    endfunction

    task automatic model_edge();
        int p, d, c;
        if (!RST_N) begin
            m_pos = 0; m_snap = 16'h0; m_an = 4'hF;
            m_seg = 7'h7F; m_seg_nz = 7'h7F; m_ft = 1'b0;
        end else begin
            p = m_pos % FRAME;
            d = p / DWELL;
            c = p % DWELL;
            if (p == 0) m_snap = bcdScore;
            m_ft = (p == 0);
            if (c < BLANK) begin
                m_an = 4'hF; m_seg = 7'h7F; m_seg_nz = 7'h7F;
            end else begin
                m_an     = ~(4'b0001 << d);
                m_seg    = ref_glyph(m_snap, d, 1'b1);
                m_seg_nz = ref_glyph(m_snap, d, 1'b0);
            end
            m_pos = p + 1;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        chk("an",         an,         m_an);
        chk("seg",        seg,        m_seg);
        chk("dp",         dp,         1);
        chk("frame_tick", frame_tick, m_ft);
        chk("an_nolz",    an_nz,      m_an);
        chk("seg_nolz",   seg_nz,     m_seg_nz);
        chk("dp_nolz",    dp_nz,      1);
        chk("ft_nolz",    ft_nz,      m_ft);
        chk("an_onehot",  ($countones(~an) <= 1), 1);
    endtask

    typedef struct packed {
        logic [15:0] bcd;
        logic [27:0] lz;   // {d3,d2,d1,d0} glyphs with leading-zero blanking
        logic [27:0] nz;   // same without blanking
    } vec_t;

    vec_t vecs [9];

    initial begin
        for (int i = 0; i < 16; i++) glyph_tbl[i] = 7'h3F;
        glyph_tbl[0] = 7'h40; glyph_tbl[1] = 7'h79; glyph_tbl[2] = 7'h24;
        glyph_tbl[3] = 7'h30; glyph_tbl[4] = 7'h19; glyph_tbl[5] = 7'h12;
        glyph_tbl[6] = 7'h02; glyph_tbl[7] = 7'h78; glyph_tbl[8] = 7'h00;
        glyph_tbl[9] = 7'h10;

        vecs[0] = '{bcd: 16'h0140, lz: {7'h7F, 7'h79, 7'h19, 7'h40}, nz: {7'h40, 7'h79, 7'h19, 7'h40}};
        vecs[1] = '{bcd: 16'h0000, lz: {7'h7F, 7'h7F, 7'h7F, 7'h40}, nz: {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[2] = '{bcd: 16'h0A05, lz: {7'h7F, 7'h3F, 7'h40, 7'h12}, nz: {7'h40, 7'h3F, 7'h40, 7'h12}};
        vecs[3] = '{bcd: 16'h0012, lz: {7'h7F, 7'h7F, 7'h79, 7'h24}, nz: {7'h40, 7'h40, 7'h79, 7'h24}};
        vecs[4] = '{bcd: 16'h0099, lz: {7'h7F, 7'h7F, 7'h10, 7'h10}, nz: {7'h40, 7'h40, 7'h10, 7'h10}};
        vecs[5] = '{bcd: 16'h9876, lz: {7'h10, 7'h00, 7'h78, 7'h02}, nz: {7'h10, 7'h00, 7'h78, 7'h02}};
        vecs[6] = '{bcd: 16'h1005, lz: {7'h79, 7'h40, 7'h40, 7'h12}, nz: {7'h79, 7'h40, 7'h40, 7'h12}};
        vecs[7] = '{bcd: 16'hF000, lz: {7'h3F, 7'h40, 7'h40, 7'h40}, nz: {7'h3F, 7'h40, 7'h40, 7'h40}};
        vecs[8] = '{bcd: 16'h00B0, lz: {7'h7F, 7'h7F, 7'h3F, 7'h40}, nz: {7'h40, 7'h40, 7'h3F, 7'h40}};

        RST_N = 1'b0;
        bcdScore = 16'h0000;
        m_pos = 0; m_snap = '0; m_an = 4'hF; m_seg = 7'h7F; m_seg_nz = 7'h7F; m_ft = 1'b0;

        // Table vectors: reset 3 cycles, release, walk one full frame.
        for (int v = 0; v < 9; v++) begin
            RST_N = 1'b0;
            for (int k = 0; k < 3; k++) tick();
            chk("rst_an", an, 4'hF);
            chk("rst_seg", seg, 7'h7F);
            bcdScore = vecs[v].bcd;
            RST_N = 1'b1;
            for (int i = 0; i < FRAME; i++) begin
                int d;
                logic [3:0] ea;
                tick();
                d  = i / DWELL;
                ea = ~(4'b0001 << d);
                if (i == 0) chk("tbl_tick", frame_tick, 1);
                if (i % DWELL == 0) chk("tbl_blank_an", an, 4'hF);
                if (i % DWELL == 2) begin
                    chk("tbl_seg",      seg,    vecs[v].lz[7*d +: 7]);
                    chk("tbl_seg_nolz", seg_nz, vecs[v].nz[7*d +: 7]);
                    chk("tbl_an",       an,     ea);
                end
            end
        end

        // No tearing: score changes in DIG0 and DIG2 only appear next frame.
        RST_N = 1'b0;
        bcdScore = 16'h0012;
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (i == 2)  chk("tear_d0", seg, 7'h24);
            if (i == 6)  chk("tear_d1", seg, 7'h79);
            if (i == 16) chk("tear_tick", frame_tick, 1);
            if (i == 18) chk("tear_new_d0", seg, 7'h10);
            if (i == 22) chk("tear_new_d1", seg, 7'h10);
            if (i == 2)  bcdScore = 16'h0055;
            if (i == 9)  bcdScore = 16'h0099;
        end

        // Single-cycle reset in the middle of DIG1.
        RST_N = 1'b0;
        bcdScore = 16'h0140;
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        RST_N = 1'b0;
        tick();
        chk("midrst_an", an, 4'hF);
        chk("midrst_seg", seg, 7'h7F);
        chk("midrst_dp", dp, 1);
        chk("midrst_tick", frame_tick, 0);
        RST_N = 1'b1;
        tick();
        chk("resume_tick", frame_tick, 1);
        tick();
        chk("resume_an", an, 4'b1110);
        chk("resume_seg", seg, 7'h40);

        // Free run: frame_tick spacing and count over three frames.
        begin
            int last = -1;
            int cnt  = 0;
            RST_N = 1'b0;
            bcdScore = 16'h2468;
            tick();
            RST_N = 1'b1;
            for (int i = 0; i < 3 * FRAME + 1; i++) begin
                tick();
                if (frame_tick) begin
                    if (last >= 0) chk("tick_period", i - last, FRAME);
                    last = i;
                    cnt++;
                end
            end
            chk("tick_count", cnt, 4);
        end

        // Random scores (biased toward zero nibbles) with occasional resets.
        for (int i = 0; i < 800; i++) begin
            RST_N = ($urandom_range(0, 99) >= 2);
            if ($urandom_range(0, 3) == 0) begin
                for (int n = 0; n < 4; n++)
                    bcdScore[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
